// File: rtl/axis_value_source.sv
// axis_value_source: AXI4-Stream master that sends a latched value as a burst of cfg_beats beats on a trigger rising edge.
// Ports: aclk/aresetn (sync, active-low) clock and reset; data/cfg_beats are sampled on an accepted trigger;
//        trigger is a level input whose rising edge starts a burst; busy is high during a burst; done is a sticky
//        completion flag; m_axis_* is the AXI4-Stream master interface (tlast marks the final beat).
// Build option: define AXIS_VALUE_SOURCE_INCR_EN so that beat i carries latched data + i.
module axis_value_source #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [AXIS_TDATA_WIDTH-1:0] data,
  input  logic [CNTR_WIDTH-1:0]       cfg_beats,
  input  logic                        trigger,
  output logic                        busy,
  output logic                        done,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast
);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  state_t                      state_q, state_d;
  logic [CNTR_WIDTH-1:0]       cnt_q, cnt_d;
  logic [AXIS_TDATA_WIDTH-1:0] data_q, data_d;
  logic                        tvalid_q, tvalid_d;
  logic                        tlast_q, tlast_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        trig_prev_q, trig_prev_d;
  logic                        rise, hs;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    busy_d      = busy_q;
    done_d      = done_q;
    trig_prev_d = trigger;
    rise        = trigger & ~trig_prev_q;
    hs          = tvalid_q & m_axis_tready;
    case (state_q)
      IDLE, DONE: begin
        if (rise) begin
          if (cfg_beats != '0) begin
            data_d   = data;
            cnt_d    = cfg_beats - CNTR_WIDTH'(1);
            done_d   = 1'b0;
            busy_d   = 1'b1;
            tvalid_d = 1'b1;
            tlast_d  = (cfg_beats == CNTR_WIDTH'(1));
            state_d  = SEND;
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      SEND: begin
        // cnt_q counts beats still to send after the one currently presented
        if (hs) begin
          if (cnt_q != '0) begin
            cnt_d   = cnt_q - CNTR_WIDTH'(1);
            tlast_d = (cnt_q == CNTR_WIDTH'(1));
`ifdef AXIS_VALUE_SOURCE_INCR_EN
            data_d  = data_q + AXIS_TDATA_WIDTH'(1);
`endif
          end else begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // trig_prev resets high so a trigger held through reset needs a fresh 0->1 edge
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      trig_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      trig_prev_q <= trig_prev_d;
    end
  end
  assign busy          = busy_q;
  assign done          = done_q;
  assign m_axis_tdata  = data_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
endmodule

// File: tb/tb_axis_value_source.sv
// tb_axis_value_source: scoreboard bench for axis_value_source with a per-burst beat-list model.
module tb_axis_value_source;
  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] data;
  logic [15:0] cfg_beats;
  logic        trigger;
  logic        busy, done;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  typedef struct {logic [31:0] d; logic l;} beat_t;
  beat_t       exp_q[$];
  logic        rpat[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic        active = 1'b0;
  logic        rmode = 1'b0;
  logic        rhold = 1'b1;
  logic        stall = 1'b0;
  logic [31:0] hold_d;
  logic        hold_l;
  axis_value_source dut (
    .aclk(aclk), .aresetn(aresetn), .data(data), .cfg_beats(cfg_beats), .trigger(trigger),
    .busy(busy), .done(done), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
  );
  always #5 aclk = ~aclk;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      if (rpat.size() != 0) m_axis_tready = rpat.pop_front();
      else if (rmode) m_axis_tready = 1'($urandom_range(0, 1));
      else m_axis_tready = rhold;
    end
  end
  initial begin
    beat_t e;
    forever begin
      @(negedge aclk);
      if (aresetn && m_axis_tvalid) begin
        if (stall) begin
          check("stall_data", m_axis_tdata, hold_d);
          check("stall_last", m_axis_tlast, hold_l);
        end
        if (m_axis_tready) begin
          stall = 1'b0;
          if (exp_q.size() == 0) check("unexpected_beat", {m_axis_tlast, m_axis_tdata}, 64'hdead);
          else begin
            e = exp_q.pop_front();
            check("beat_data", m_axis_tdata, e.d);
            check("beat_last", m_axis_tlast, e.l);
            if (e.l) active = 1'b0;
          end
        end else begin
          stall  = 1'b1;
          hold_d = m_axis_tdata;
          hold_l = m_axis_tlast;
        end
      end else stall = 1'b0;
    end
  end
  // burst model: a trigger is accepted only when no burst is outstanding; beat i = d (+ i when incrementing)
  task automatic pulse(input logic [31:0] d, input logic [15:0] n);
    logic acc;
    beat_t b;
    acc = !active;
    data = d;
    cfg_beats = n;
    trigger = 1'b1;
    if (acc) begin
      for (int i = 0; i < int'(n); i++) begin
`ifdef AXIS_VALUE_SOURCE_INCR_EN
        b.d = d + 32'(i);
`else
        b.d = d;
`endif
        b.l = (i == int'(n) - 1);
        exp_q.push_back(b);
      end
      active = (n != 0);
    end
    @(posedge aclk);
    #1;
    trigger = 1'b0;
    data = $urandom;
    cfg_beats = 16'($urandom);
    @(negedge aclk);
    if (acc) begin
      check("start_tvalid", m_axis_tvalid, n != 0);
      check("start_busy", busy, n != 0);
      check("start_done", done, n == 0);
    end
    @(posedge aclk);
    #1;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (n < 2000 && !(exp_q.size() == 0 && !m_axis_tvalid)) begin
      @(negedge aclk);
      n++;
    end
    check("idle_timeout", n < 2000, 1);
    check("end_done", done, 1);
    check("end_busy", busy, 0);
    @(posedge aclk);
    #1;
  endtask
  task automatic chk_reset_vals();
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
  endtask
  initial begin
    aresetn = 1'b0;
    trigger = 1'b1;
    data = 32'h0;
    cfg_beats = 16'd4;
    rhold = 1'b1;
    repeat (4) @(posedge aclk);
    #1;
    chk_reset_vals();
    aresetn = 1'b1;
    repeat (5) @(posedge aclk);
    #1;
    chk_reset_vals();
    trigger = 1'b0;
    @(posedge aclk);
    #1;
    pulse(32'hDEADBEEF, 16'd4);
    repeat (3) begin
      @(negedge aclk);
      check("burst_consecutive", m_axis_tvalid, 1);
    end
    @(negedge aclk);
    check("burst_end_tvalid", m_axis_tvalid, 0);
    check("burst_end_done", done, 1);
    @(posedge aclk);
    #1;
    wait_idle();
    rpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    pulse(32'h12345678, 16'd3);
    wait_idle();
    pulse(32'hA5A5A5A5, 16'd0);
    wait_idle();
    pulse(32'h0BADF00D, 16'd1);
    wait_idle();
    rmode = 1'b1;
    pulse(32'hCAFE0000, 16'd5);
    repeat (2) @(posedge aclk);
    #1;
    pulse(32'h11111111, 16'd7);
    wait_idle();
    repeat (10) @(posedge aclk);
    #1;
    rmode = 1'b0;
    pulse(32'hFFFFFFFE, 16'd4);
    wait_idle();
    pulse(32'h55AA55AA, 16'd5);
    aresetn = 1'b0;
    rhold = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    chk_reset_vals();
    exp_q.delete();
    active = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    rhold = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    rmode = 1'b1;
    pulse(32'h00C0FFEE, 16'd300);
    wait_idle();
    for (int k = 0; k < 30; k++) begin
      rmode = 1'($urandom_range(0, 1));
      pulse($urandom, 16'($urandom_range(0, 8)));
      if ($urandom_range(0, 3) == 0) pulse($urandom, 16'($urandom_range(1, 4)));
      wait_idle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/axis_value_source.md
Name: axis_value_source

Overview:
- AXI4-Stream master that sends a latched parallel value as a burst of beats when a trigger edge arrives.
- Counterpart to the stream-snapshot capture block: that block turns one stream sample into a register; this block turns a register into a stream burst.
- Used to inject configuration or test words into downstream DSP or DMA stream chains.
- Single clock domain, full tvalid/tready back-pressure support, tlast on the final beat.

Parameters:
- AXIS_TDATA_WIDTH, 32: width of data and m_axis_tdata.
- CNTR_WIDTH, 16: width of cfg_beats and the internal beat counter.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  synchronous, active-low reset.
- data  in  AXIS_TDATA_WIDTH  value to transmit; sampled only on an accepted trigger.
- cfg_beats  in  CNTR_WIDTH  number of beats per burst; sampled only on an accepted trigger.
- trigger  in  1  level input; a rising edge starts a burst.
- busy  out  1  high while a burst is in progress.
- done  out  1  sticky completion flag.
- m_axis_tdata  out  AXIS_TDATA_WIDTH  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready from downstream.
- m_axis_tlast  out  1  high on the final beat of a burst.

Behaviour:
- Reset values (aresetn low at a clock edge):
  - state IDLE; m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, done=0, beat counter=0.
  - Trigger history register = 1, so a trigger held high through reset does not start a burst; a fresh 0->1 transition is required.
- Edge detect: rise = trigger & ~trig_prev; trig_prev <= trigger every cycle.
- States: IDLE, SEND, DONE. All outputs are registered.
- IDLE or DONE, rise=1, cfg_beats!=0:
  - Latch data into the data register; load counter = cfg_beats-1.
  - Clear done; set busy=1, m_axis_tvalid=1.
  - Set m_axis_tlast=1 if cfg_beats==1.
  - Next state SEND.
  - Latency: tvalid is high in the cycle immediately after the edge at which rise was sampled.
- IDLE or DONE, rise=1, cfg_beats==0:
  - No beats are emitted.
  - done=1 from the next cycle; state DONE; busy stays 0.
- SEND, handshake (tvalid & tready), counter!=0:
  - Decrement the counter.
  - Set tlast=1 when the new counter value is 0.
  - tvalid stays 1.
- SEND, handshake, counter==0 (tlast beat accepted):
  - Next cycle: tvalid=0, tlast=0, busy=0, done=1; state DONE.
  - No extra beat is emitted.
- SEND, tvalid & ~tready:
  - m_axis_tdata and m_axis_tlast hold exactly.
  - tvalid is never deasserted before the handshake.
- SEND, rise=1: ignored. No restart and no queuing; trig_prev still updates.
- data and cfg_beats changes during SEND have no effect on the burst in progress.
- done stays high until the next accepted trigger, or until reset.
- Beat count is exactly cfg_beats; the maximum is 2^CNTR_WIDTH-1.
- Reset mid-burst: all outputs go to reset values on the next edge. The partial burst is abandoned with no tlast; downstream must tolerate this.
- tready is ignored whenever tvalid=0.

Optional Feature:
- Macro: AXIS_VALUE_SOURCE_INCR_EN.
- Defined:
  - Beat i (0-based) carries latched_data + i, modulo 2^AXIS_TDATA_WIDTH; wraps silently.
  - The data register increments on each non-final handshake.
  - The value still holds stable under back-pressure.
- Undefined:
  - Every beat carries latched_data unchanged.
  - No adder is synthesised.

Test Plan:
- Reset with trigger held high, then release reset with tready=1 -> no beat emitted; done=0, busy=0. Drop trigger, then raise it -> burst starts.
- data=0xDEADBEEF, cfg_beats=4, tready=1, trigger 0->1 -> tvalid the next cycle; 4 consecutive beats of 0xDEADBEEF; tlast only on the 4th; done=1 the cycle after.
- cfg_beats=3, tready toggling 1,0,0,1,0,1 -> exactly 3 handshakes; tdata/tlast stable during stalls; tlast on the 3rd accepted beat only.
- cfg_beats=0, trigger edge -> no tvalid; done=1 one cycle later. Then cfg_beats=1 with a new edge -> a single beat with tlast=1; done cleared while busy.
- Second trigger edge mid-burst (cfg_beats=5) -> still exactly 5 beats; no second burst. aresetn low during beat 2 -> tvalid=0, busy=0, done=0 the next cycle.
- With AXIS_VALUE_SOURCE_INCR_EN, data=0xFFFFFFFE, cfg_beats=4 -> beats 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.
